// File: rtl/pwm_audio_out.sv
// pwm_audio_out
//
// Audio output stage fed by the filter selection block. Signed 8-bit
// samples arrive one per `done` strobe and are buffered in a small
// circular FIFO. The FIFO is drained at a fixed audio sample rate. Each
// drained sample is converted to offset binary and drives a free-running
// 8-bit PWM that feeds the board's amplifier / RC low-pass. Sticky
// overflow/underflow flags are provided for debug LEDs.
//
// Parameters
//   SAMPLE_PERIOD : clock cycles per output sample (>= 2)
//   FIFO_DEPTH    : FIFO entries (power of 2, >= 2)
//
// Ports
//   clock      : system clock
//   reset      : synchronous, active-high reset
//   done       : one-cycle strobe, audio_in valid this cycle
//   audio_in   : signed two's-complement sample
//   mute       : forces midscale duty (0x80) from the next PWM boundary
//   pwm_out    : registered PWM waveform
//   fifo_count : current FIFO occupancy
//   overflow   : sticky, a sample was dropped on a full FIFO
//   underflow  : sticky, a sample tick found the FIFO empty

module pwm_audio_out #(
  parameter int unsigned SAMPLE_PERIOD = 2268,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          done,
  input  logic [7:0]                    audio_in,
  input  logic                          mute,
  output logic                          pwm_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    cur_sample;
  logic [7:0]    pwm_cnt;
  logic [7:0]    duty_q;
  logic [7:0]    duty_next;

  logic tick;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push_ok;
  logic push_drop;

  assign tick       = (tick_cnt == TW'(SAMPLE_PERIOD - 1));
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  // A pop needs data already resident; there is no bypass from the write
  // port, so a push into an empty FIFO on a tick still counts as underflow.
  assign pop = tick && !fifo_empty;

  // A full FIFO can still accept a push in the same cycle it is popped,
  // since the pop frees the slot the push lands in.
  assign push_ok   = done && (!fifo_full || pop);
  assign push_drop = done && fifo_full && !pop;

  // Offset-binary conversion: flipping the sign bit maps -128..127 onto 0..255.
  assign duty_next = mute ? 8'h80 : {~cur_sample[7], cur_sample[6:0]};

  // Sample storage carries no reset; stale contents are unreachable once
  // the pointers and occupancy counter are cleared.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= audio_in;
    end
  end

  // FIFO control: pointers wrap naturally because FIFO_DEPTH is a power of
  // two, while occupancy is tracked explicitly so full and empty are never
  // ambiguous.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      cur_sample <= 8'h00;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        cur_sample <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push_drop) begin
        overflow <= 1'b1;
      end
      if (tick && fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Sample-rate divider: counts 0..SAMPLE_PERIOD-1, the tick is its last count.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // PWM: duty is only reloaded at the end of a 256-cycle period so each
  // period is generated with a single, consistent duty value.
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_cnt <= 8'h00;
      duty_q  <= 8'h80;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'h01;
      if (pwm_cnt == 8'hFF) begin
        duty_q <= duty_next;
      end
      pwm_out <= (pwm_cnt < duty_q);
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out
//
// Directed self-checking bench for pwm_audio_out with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge. `cyc`
// counts rising edges since reset was released, so a tick edge happens when
// cyc reaches a multiple of SAMPLE_PERIOD. PWM period P covers the pwm_out
// samples at cyc 256P+1 .. 256P+256.

module tb_pwm_audio_out;

  localparam int SAMPLE_PERIOD = 2268;
  localparam int FIFO_DEPTH    = 4;

  logic                         clock = 1'b0;
  logic                         reset;
  logic                         done;
  logic [7:0]                   audio_in;
  logic                         mute;
  logic                         pwm_out;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         overflow;
  logic                         underflow;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int highs;

  always #5 clock = ~clock;

  pwm_audio_out #(
    .SAMPLE_PERIOD (SAMPLE_PERIOD),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .done       (done),
    .audio_in   (audio_in),
    .mute       (mute),
    .pwm_out    (pwm_out),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic next_cycle();
    @(negedge clock);
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) next_cycle();
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle push: the sample is captured on the next rising edge.
  task automatic apply_stimulus(input logic [7:0] sample);
    done     = 1'b1;
    audio_in = sample;
    next_cycle();
    done     = 1'b0;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    done     = 1'b0;
    mute     = 1'b0;
    audio_in = 8'h00;
    next_cycle();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_pwm_out"},    pwm_out,        0);
    check_output({tag, "_fifo_count"}, fifo_count,     0);
    check_output({tag, "_overflow"},   overflow,       0);
    check_output({tag, "_underflow"},  underflow,      0);
    check_output({tag, "_duty_q"},     dut.duty_q,     8'h80);
    check_output({tag, "_cur_sample"}, dut.cur_sample, 8'h00);
  endtask

  // Counts pwm_out highs across one full PWM period; call with cyc at 256P.
  task automatic measure_period(output int count);
    count = 0;
    repeat (256) begin
      next_cycle();
      if (pwm_out === 1'b1) count++;
    end
  endtask

  initial begin
    $display("[TB] start");

    // Reset default: midscale duty, underflow on the first empty tick.
    apply_reset();
    check_reset_state("rst");
    measure_period(highs);
    check_output("rst_duty_highs", highs, 128);
    run_to(SAMPLE_PERIOD - 1);
    check_output("rst_underflow_pre_tick", underflow, 0);
    run_to(SAMPLE_PERIOD);
    check_output("rst_underflow_first_tick", underflow, 1);
    check_output("rst_fifo_count_after_tick", fifo_count, 0);

    // Single sample path: +127 gives full duty, -128 gives zero duty.
    apply_reset();
    apply_stimulus(8'h7F);
    check_output("single_push_count", fifo_count, 1);
    run_to(2267);
    check_output("single_cur_before_tick", dut.cur_sample, 8'h00);
    run_to(2268);
    check_output("single_cur_after_tick", dut.cur_sample, 8'h7F);
    check_output("single_count_after_pop", fifo_count, 0);
    run_to(2303);
    check_output("single_duty_before_boundary", dut.duty_q, 8'h80);
    run_to(2304);
    check_output("single_duty_after_boundary", dut.duty_q, 8'hFF);
    measure_period(highs);
    check_output("single_duty_ff_highs", highs, 255);
    run_to(2600);
    apply_stimulus(8'h80);
    run_to(4536);
    check_output("single_cur_neg", dut.cur_sample, 8'h80);
    check_output("single_no_underflow", underflow, 0);
    run_to(4608);
    check_output("single_duty_00", dut.duty_q, 8'h00);
    measure_period(highs);
    check_output("single_duty_00_highs", highs, 0);

    // Overflow: five back-to-back pushes, the fifth is dropped.
    apply_reset();
    apply_stimulus(8'd1);
    apply_stimulus(8'd2);
    apply_stimulus(8'd3);
    apply_stimulus(8'd4);
    check_output("ovf_count_full", fifo_count, 4);
    check_output("ovf_flag_before_drop", overflow, 0);
    apply_stimulus(8'd5);
    check_output("ovf_count_after_drop", fifo_count, 4);
    check_output("ovf_flag_after_drop", overflow, 1);
    run_to(2268);
    check_output("ovf_pop1", dut.cur_sample, 8'd1);
    check_output("ovf_count_pop1", fifo_count, 3);
    run_to(4536);
    check_output("ovf_pop2", dut.cur_sample, 8'd2);
    run_to(6804);
    check_output("ovf_pop3", dut.cur_sample, 8'd3);
    run_to(9072);
    check_output("ovf_pop4", dut.cur_sample, 8'd4);
    check_output("ovf_count_empty", fifo_count, 0);
    check_output("ovf_no_underflow_yet", underflow, 0);
    run_to(11340);
    check_output("ovf_sample5_never_out", dut.cur_sample, 8'd4);
    check_output("ovf_underflow_after", underflow, 1);

    // Full FIFO with a push landing on the tick cycle.
    apply_reset();
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    apply_stimulus(8'h33);
    apply_stimulus(8'h44);
    check_output("full_count", fifo_count, 4);
    run_to(2267);
    apply_stimulus(8'h55);
    check_output("full_pop_count", fifo_count, 4);
    check_output("full_pop_head", dut.cur_sample, 8'h11);
    check_output("full_pop_no_overflow", overflow, 0);
    run_to(4536);
    check_output("full_pop2", dut.cur_sample, 8'h22);
    run_to(11340);
    check_output("full_pop5", dut.cur_sample, 8'h55);
    check_output("full_count_drained", fifo_count, 0);
    check_output("full_overflow_still_clear", overflow, 0);

    // Empty FIFO with a push landing on the tick cycle: no bypass.
    apply_reset();
    run_to(2267);
    apply_stimulus(8'h10);
    check_output("empty_push_underflow", underflow, 1);
    check_output("empty_push_cur_held", dut.cur_sample, 8'h00);
    check_output("empty_push_count", fifo_count, 1);
    run_to(4536);
    check_output("empty_push_next_pop", dut.cur_sample, 8'h10);
    check_output("empty_push_count_after", fifo_count, 0);

    // Mute with pops continuing, then a one-cycle reset mid-period.
    apply_reset();
    mute = 1'b1;
    apply_stimulus(8'h7F);
    apply_stimulus(8'h80);
    apply_stimulus(8'h01);
    apply_stimulus(8'hC0);
    run_to(2268);
    check_output("mute_pop_continues", dut.cur_sample, 8'h7F);
    check_output("mute_count_after_pop", fifo_count, 3);
    run_to(2300);
    apply_stimulus(8'h05);
    apply_stimulus(8'h06);
    check_output("mute_overflow_set", overflow, 1);
    check_output("mute_count_full", fifo_count, 4);
    run_to(2304);
    check_output("mute_duty_mid", dut.duty_q, 8'h80);
    measure_period(highs);
    check_output("mute_duty_highs", highs, 128);
    mute = 1'b0;
    run_to(2816);
    check_output("unmute_duty", dut.duty_q, 8'hFF);
    run_to(3000);
    reset = 1'b1;
    next_cycle();
    check_reset_state("midrst");
    check_output("midrst_pwm_cnt", dut.pwm_cnt, 8'h00);
    reset = 1'b0;
    cyc   = 0;
    measure_period(highs);
    check_output("midrst_duty_highs", highs, 128);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
